bsk_prd_ctrl: RTL and testbench
===============================

# bsk_prd_ctrl

Bus-master controller that sequences all accesses to one PRD command-receiver peripheral over its 16-bit register bus (2-bit address, active-low strobes). It polls the two command registers, checks their integrity, confirms the result over consecutive polls, and publishes it upstream. It also writes the indication register (addr 2'b10) and the control register (addr 2'b11, bit 0 = test_en) whenever the upstream requested value changes. It sits between the board-level CPU-side logic and the peripheral, so that the peripheral only ever has one master.

## Interface
- POLL_PERIOD, 2000: clock cycles from the start of one poll sequence to the start of the next; minimum 32.
- STROBE_CYC, 4: length in cycles of the oRd/oWr low phase; range 1..15.
- CONFIRM, 2: number of consecutive identical, consistent polls required before oCom updates; range 1..7.

Ports:
- clk  in  1  system clock.
- iRes  in  1  asynchronous, active-high reset.
- oCS  out  1  peripheral chip select, active low.
- oA  out  2  register address.
- oRd  out  1  read strobe, active low.
- oWr  out  1  write strobe, active low.
- oD  out  16  write data.
- oDOe  out  1  write-data output enable, high = drive the bus.
- iD  in  16  read data from the bus.
- iInd  in  16  requested indication word.
- iTestEn  in  1  requested test_en bit.
- oCom  out  16  confirmed command word (raw reg 2'b00 value).
- oComStb  out  1  one-cycle pulse when oCom changes.
- oErr  out  1  last poll failed the integrity check.
- oErrCnt  out  8  saturating count of failed polls.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A step index selects the access: 0 = read 2'b00, 1 = read 2'b01, 2 = write 2'b10, 3 = write 2'b11.
- Poll timer: a free-running counter that wraps at POLL_PERIOD-1. On wrap, a sequence starts from IDLE with step 0.
- If a sequence is still running when the timer wraps, the start is deferred. The sequence then starts on the first IDLE cycle, and the timer restarts from 0 at that point.
- SETUP, 1 cycle: oCS=0, oA=step address. For writes, oD and oDOe=1 are also asserted here.
- STROBE, STROBE_CYC cycles: oRd=0 or oWr=0.
  - Reads: iD is captured on the last STROBE cycle.
- HOLD, 1 cycle: the strobe returns to 1; oCS, oA and oD stay stable. oDOe drops at HOLD exit. The peripheral latches on the rising edge of oWr.
- Step 2 runs only if iInd ≠ shadow_ind. Step 3 runs only if iTestEn ≠ shadow_te. Skipped steps take 0 cycles.
- iInd and iTestEn are sampled at SETUP. The shadow register updates at HOLD exit. Write data for step 3 is {15'b0, iTestEn}.
- Integrity check, evaluated after step 1: the poll is consistent iff r01 == {r00[7:0], r00[15:8]}.
- On a consistent poll:
  - oErr is cleared.
  - If r00 equals the candidate value, the confirm count increments (saturating at CONFIRM). Otherwise the candidate becomes r00 and the count is set to 1.
  - When the count reaches CONFIRM and the candidate ≠ oCom, oCom is loaded and oComStb pulses.
- On an inconsistent poll: oErr is set, the confirm count is reset to 0, and oErrCnt increments (saturating at 8'hFF).

## Timing
- Reset values:
  - Bus outputs: oCS=1, oRd=1, oWr=1, oA=0, oD=0, oDOe=0.
  - Upstream outputs: oCom=0, oComStb=0, oErr=0, oErrCnt=0.
  - Internal: shadow_ind=0 and shadow_te=0, matching the peripheral's reset contents. Candidate=0, confirm count=0, FSM=IDLE, timer=0.
- The first sequence starts POLL_PERIOD cycles after reset is released.
- Access length is STROBE_CYC+2 cycles; with defaults, 6 cycles. At least one IDLE cycle (oCS=1) separates accesses.
- A full read-only sequence takes 2·(STROBE_CYC+3) cycles.
- oComStb and oErr update in the cycle after step 1's HOLD.
- Assertion of iRes at any point returns everything to its reset state asynchronously. Bus strobes deassert immediately; a partial write may be lost.
- All outputs are registered.

## Configuration
- BSK_PRD_CTRL_ERRCNT_EN defined: oErrCnt is the 8-bit saturating counter described above.
- Not defined: the counter is not built and oErrCnt is tied to 8'h00. oErr behaviour is unchanged.

## Test plan
- Reset, then model returns r00=16'hC3E1 and r01=16'hE1C3 with CONFIRM=2. Required: no oComStb after poll 1; after poll 2, oCom=16'hC3E1 with one oComStb pulse; no pulse on poll 3.
- Model returns r00=16'hC3E1 and r01=16'hC3E1. Required: oErr=1, oErrCnt increments by one per poll, oCom unchanged. A following consistent poll clears oErr.
- Set iInd=16'h1111 mid-period. Required: the next sequence contains a write to 2'b10 with oD=16'h1111. oWr is low for exactly 4 cycles, with oA/oCS/oD stable from SETUP through HOLD. The following sequence has no write.
- Set iTestEn=1. Required: write to 2'b11 with oD=16'h0001. Then set iTestEn=0: write with oD=16'h0000.
- Assert iRes during the STROBE phase of the step-2 write. Required: in the same cycle oWr=1, oCS=1, oDOe=1→0; all outputs at reset values; the next sequence repeats the write because shadow_ind=0.
- Force 300 inconsistent polls. Required: oErrCnt saturates at 8'hFF. With BSK_PRD_CTRL_ERRCNT_EN undefined, oErrCnt stays 8'h00.

Source files
------------

// File: rtl/bsk_prd_ctrl.sv
// bsk_prd_ctrl: single bus master for a PRD command-receiver peripheral.
// It polls command registers 00/01 every POLL_PERIOD cycles and checks that
// reg 01 is the byte-swapped copy of reg 00. A value is published on oCom only
// after CONFIRM consecutive identical, consistent polls. Indication (reg 10)
// and control (reg 11, bit 0 = test_en) are written only when the requested
// value differs from what was last written.
// Optional feature macro: BSK_PRD_CTRL_ERRCNT_EN builds the saturating failed-
// poll counter on oErrCnt; without it oErrCnt is tied to zero.
module bsk_prd_ctrl #(
  parameter int POLL_PERIOD = 2000,
  parameter int STROBE_CYC  = 4,
  parameter int CONFIRM     = 2
) (
  input  logic        clk,
  input  logic        iRes,
  output logic        oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  output logic [15:0] oD,
  output logic        oDOe,
  input  logic [15:0] iD,
  input  logic [15:0] iInd,
  input  logic        iTestEn,
  output logic [15:0] oCom,
  output logic        oComStb,
  output logic        oErr,
  output logic [7:0]  oErrCnt
);

  localparam int              TMR_W    = $clog2(POLL_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_PERIOD - 1);
  localparam logic [3:0]      STB_LAST = 4'(STROBE_CYC - 1);
  localparam logic [2:0]      CONF     = 3'(CONFIRM);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t           state;
  logic [1:0]       step;        // access in flight, or next access while idle in a sequence
  logic             in_seq;      // a poll sequence is in progress
  logic             pend;        // timer wrapped while busy; start at first free cycle
  logic [TMR_W-1:0] timer;
  logic [3:0]       stb_cnt;
  logic [15:0]      r00;
  logic [15:0]      r01;
  logic [15:0]      shadow_ind;  // last value written to reg 10 (peripheral resets to 0)
  logic             shadow_te;   // last value written to reg 11 bit 0
  logic [15:0]      cand;
  logic [2:0]       conf_cnt;

  logic       wrap;
  logic       free;
  logic       start;
  logic       need_ind;
  logic       need_te;
  logic       go;
  logic [1:0] go_step;
  logic       end_seq;
  logic       eval;
  logic       consistent;
  logic [2:0] cnt_inc;
  logic [2:0] nxt_cnt;

  assign wrap       = (timer == TMR_LAST);
  assign free       = (state == IDLE) && !in_seq;
  assign start      = free && (wrap || pend);
  assign need_ind   = (iInd != shadow_ind);
  assign need_te    = (iTestEn != shadow_te);
  assign eval       = (state == HOLD) && (step == 2'd1);
  assign consistent = (r01 == {r00[7:0], r00[15:8]});
  assign cnt_inc    = (conf_cnt >= CONF) ? CONF : conf_cnt + 3'd1;
  assign nxt_cnt    = (r00 == cand) ? cnt_inc : 3'd1;

  // Pick the next access from IDLE; unneeded writes are skipped without cost.
  always_comb begin
    go      = 1'b0;
    go_step = step;
    end_seq = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        go      = 1'b1;
        go_step = 2'd0;
      end else if (in_seq) begin
        case (step)
          2'd2: begin
            if (need_ind) begin
              go      = 1'b1;
              go_step = 2'd2;
            end else if (need_te) begin
              go      = 1'b1;
              go_step = 2'd3;
            end else begin
              end_seq = 1'b1;
            end
          end
          2'd3: begin
            if (need_te) go = 1'b1;
            else         end_seq = 1'b1;
          end
          default: go = 1'b1;
        endcase
      end
    end
  end

  // Poll timer: free-running, restarted whenever a sequence is launched.
  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      timer <= '0;
      pend  <= 1'b0;
    end else begin
      if (start || wrap) timer <= '0;
      else               timer <= timer + TMR_W'(1);
      if (start)     pend <= 1'b0;
      else if (wrap) pend <= 1'b1;
    end
  end

  // Bus access FSM with registered strobes, read capture and write shadows.
  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      state      <= IDLE;
      step       <= 2'd0;
      in_seq     <= 1'b0;
      stb_cnt    <= 4'd0;
      oCS        <= 1'b1;
      oA         <= 2'd0;
      oRd        <= 1'b1;
      oWr        <= 1'b1;
      oD         <= 16'h0000;
      oDOe       <= 1'b0;
      r00        <= 16'h0000;
      r01        <= 16'h0000;
      shadow_ind <= 16'h0000;
      shadow_te  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            state  <= SETUP;
            step   <= go_step;
            in_seq <= 1'b1;
            oCS    <= 1'b0;
            oA     <= go_step;
            if (go_step[1]) begin
              oDOe <= 1'b1;
              oD   <= go_step[0] ? {15'b0, iTestEn} : iInd;
            end
          end else if (end_seq) begin
            in_seq <= 1'b0;
          end
        end
        SETUP: begin
          state   <= STROBE;
          stb_cnt <= 4'd0;
          if (step[1]) oWr <= 1'b0;
          else         oRd <= 1'b0;
        end
        STROBE: begin
          if (stb_cnt == STB_LAST) begin
            state <= HOLD;
            oRd   <= 1'b1;
            oWr   <= 1'b1;
            if (!step[1]) begin
              if (step[0]) r01 <= iD;
              else         r00 <= iD;
            end
          end else begin
            stb_cnt <= stb_cnt + 4'd1;
          end
        end
        HOLD: begin
          state <= IDLE;
          oCS   <= 1'b1;
          oDOe  <= 1'b0;
          if (step == 2'd2) shadow_ind <= oD;
          if (step == 2'd3) begin
            shadow_te <= oD[0];
            in_seq    <= 1'b0;
          end
          step <= step + 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Integrity check and confirmation after the second read of each poll.
  always_ff @(posedge clk or posedge iRes) begin
    if (iRes) begin
      cand     <= 16'h0000;
      conf_cnt <= 3'd0;
      oCom     <= 16'h0000;
      oComStb  <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      oComStb <= 1'b0;
      if (eval) begin
        if (consistent) begin
          oErr     <= 1'b0;
          cand     <= r00;
          conf_cnt <= nxt_cnt;
          if ((nxt_cnt == CONF) && (r00 != oCom)) begin
            oCom    <= r00;
            oComStb <= 1'b1;
          end
        end else begin
          oErr     <= 1'b1;
          conf_cnt <= 3'd0;
        end
      end
    end
  end

`ifdef BSK_PRD_CTRL_ERRCNT_EN
  // Saturating count of polls that failed the integrity check.
  always_ff @(posedge clk or posedge iRes) begin
    if (iRes)                                         oErrCnt <= 8'h00;
    else if (eval && !consistent && oErrCnt != 8'hFF) oErrCnt <= oErrCnt + 8'h01;
  end
`else
  assign oErrCnt = 8'h00;
`endif

endmodule

// File: tb/tb_bsk_prd_ctrl.sv
// Scoreboard bench for bsk_prd_ctrl: a peripheral model answers reads, the
// stimulus pushes expected polls/commands/writes, monitors pop and compare.
module tb_bsk_prd_ctrl;
  localparam int P = 64;
  localparam int S = 4;
`ifdef BSK_PRD_CTRL_ERRCNT_EN
  localparam bit ECEN = 1'b1;
`else
  localparam bit ECEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        iRes;
  logic        oCS, oRd, oWr, oDOe, oComStb, oErr, iTestEn;
  logic [1:0]  oA;
  logic [15:0] oD, iD, iInd, oCom;
  logic [7:0]  oErrCnt;
  logic [15:0] m_r00, m_r01;

  bsk_prd_ctrl #(.POLL_PERIOD(P), .STROBE_CYC(S), .CONFIRM(2)) dut (
    .clk(clk), .iRes(iRes), .oCS(oCS), .oA(oA), .oRd(oRd), .oWr(oWr),
    .oD(oD), .oDOe(oDOe), .iD(iD), .iInd(iInd), .iTestEn(iTestEn),
    .oCom(oCom), .oComStb(oComStb), .oErr(oErr), .oErrCnt(oErrCnt));

  always #5 clk = ~clk;

  assign iD = (!oCS && !oRd) ? ((oA == 2'd0) ? m_r00 : (oA == 2'd1) ? m_r01 : 16'h0000) : 16'h0000;

  typedef struct packed {logic [1:0] a; logic [15:0] d;} wr_t;
  typedef struct packed {logic err; logic [7:0] cnt;} poll_t;
  wr_t         exp_wr[$];
  poll_t       exp_poll[$];
  logic [15:0] exp_com[$];

  int total = 0;
  int passed = 0;
  int polls_done = 0;
  int ec = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    total++;
    $display("FAIL %s actual=%0h required=none", name, act);
  endtask

  // Monitors: command pulses, poll results and write transactions
  logic       prev_cs = 1'b1;
  logic       prev_doe = 1'b0;
  logic [1:0] prev_a = 2'd0;
  bit         wr_act = 1'b0;
  bit         wstab;
  logic [1:0] wa;
  logic [15:0] wd;
  int         wlow, wlen;
  wr_t        w;
  poll_t      p;

  always @(negedge clk) begin
    if (iRes) begin
      wr_act  = 1'b0;
      prev_cs = 1'b1;
    end else begin
      if (oComStb) begin
        if (exp_com.size() == 0) fail_unexp("unexpected_comstb", oCom);
        else chk("ocom", oCom, exp_com.pop_front());
      end
      if (!prev_cs && prev_a == 2'd1 && !prev_doe && oCS) begin
        polls_done++;
        if (exp_poll.size() == 0) fail_unexp("unexpected_poll", oErr);
        else begin
          p = exp_poll.pop_front();
          chk("oerr", oErr, p.err);
          chk("oerrcnt", oErrCnt, p.cnt);
        end
      end
      if (!wr_act && !oCS && oDOe) begin
        wr_act = 1'b1; wa = oA; wd = oD; wlow = 0; wlen = 1; wstab = 1'b1;
      end else if (wr_act) begin
        if (oCS) begin
          wr_act = 1'b0;
          chk("doe_drop", oDOe, 1'b0);
          if (exp_wr.size() == 0) fail_unexp("unexpected_write", {14'b0, wa, wd});
          else begin
            w = exp_wr.pop_front();
            chk("wr_addr", wa, w.a);
            chk("wr_data", wd, w.d);
            chk("wr_strobe_len", wlow, S);
            chk("wr_access_len", wlen, S + 2);
            chk("wr_stable", wstab, 1'b1);
          end
        end else begin
          wlen++;
          if (!oWr) wlow++;
          if (oA != wa || oD != wd || !oDOe) wstab = 1'b0;
        end
      end
      prev_cs = oCS; prev_a = oA; prev_doe = oDOe;
    end
  end

  task automatic wait_poll();
    int tgt = polls_done + 1;
    int n = 0;
    while (polls_done < tgt && n < 4 * P) begin
      @(negedge clk); #1;
      n++;
    end
    if (polls_done < tgt) fail_unexp("poll_timeout", n);
  endtask

  // One poll: set model registers, queue expectations, wait, then let the sequence finish
  task automatic poll(input logic [15:0] r00, input logic [15:0] r01, input logic err,
                      input bit pulse, input logic [15:0] com, input int settle);
    m_r00 = r00;
    m_r01 = r01;
    exp_poll.push_back('{err: err, cnt: ECEN ? 8'(ec) : 8'h00});
    if (pulse) exp_com.push_back(com);
    wait_poll();
    repeat (settle) @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ocs"}, oCS, 1'b1);
    chk({tag, "_ord"}, oRd, 1'b1);
    chk({tag, "_owr"}, oWr, 1'b1);
    chk({tag, "_oa"}, oA, 2'd0);
    chk({tag, "_od"}, oD, 16'h0000);
    chk({tag, "_odoe"}, oDOe, 1'b0);
    chk({tag, "_ocom"}, oCom, 16'h0000);
    chk({tag, "_ocomstb"}, oComStb, 1'b0);
    chk({tag, "_oerr"}, oErr, 1'b0);
    chk({tag, "_oerrcnt"}, oErrCnt, 8'h00);
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    iRes = 1'b1; iInd = 16'h0000; iTestEn = 1'b0;
    m_r00 = 16'hC3E1; m_r01 = 16'hE1C3;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk); #1;
    iRes = 1'b0;
    n = 0;
    while (oCS && n < 2 * P) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_start_cycles", n, P);

    // confirmation of a new command
    poll(16'hC3E1, 16'hE1C3, 1'b0, 1'b0, 16'h0, 20);
    poll(16'hC3E1, 16'hE1C3, 1'b0, 1'b1, 16'hC3E1, 20);
    poll(16'hC3E1, 16'hE1C3, 1'b0, 1'b0, 16'h0, 20);
    // inconsistent polls
    for (int i = 0; i < 3; i++) begin
      ec++;
      poll(16'hC3E1, 16'hC3E1, 1'b1, 1'b0, 16'h0, 20);
    end
    poll(16'hC3E1, 16'hE1C3, 1'b0, 1'b0, 16'h0, 20);
    poll(16'hC3E1, 16'hE1C3, 1'b0, 1'b0, 16'h0, 20);
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    poll(16'h1234, 16'h3412, 1'b0, 1'b1, 16'h1234, 20);

    // indication and test_en writes
    iInd = 16'h1111; exp_wr.push_back('{a: 2'd2, d: 16'h1111});
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    iTestEn = 1'b1; exp_wr.push_back('{a: 2'd3, d: 16'h0001});
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    iTestEn = 1'b0; exp_wr.push_back('{a: 2'd3, d: 16'h0000});
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    iInd = 16'h2222; iTestEn = 1'b1;
    exp_wr.push_back('{a: 2'd2, d: 16'h2222});
    exp_wr.push_back('{a: 2'd3, d: 16'h0001});
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    iTestEn = 1'b0; exp_wr.push_back('{a: 2'd3, d: 16'h0000});
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    chk("writes_done", exp_wr.size(), 0);

    // reset in the middle of a write strobe
    iInd = 16'h3333;
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 0);
    n = 0;
    while (!(!oWr && oA == 2'd2) && n < 2 * P) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_wr_low", oWr, 1'b0);
    #1;
    chk("abort_doe_before", oDOe, 1'b1);
    iRes = 1'b1;
    #1;
    chk_reset_outputs("abort");
    ec = 0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    #1;
    iRes = 1'b0;
    exp_wr.push_back('{a: 2'd2, d: 16'h3333});
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    poll(16'h1234, 16'h3412, 1'b0, 1'b1, 16'h1234, 20);
    chk("rewrite_done", exp_wr.size(), 0);

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      if (ec < 255) ec++;
      poll(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0, 20);
    end
    poll(16'h1234, 16'h3412, 1'b0, 1'b0, 16'h0, 20);
    chk("final_ocom", oCom, 16'h1234);

    chk("exp_wr_empty", exp_wr.size(), 0);
    chk("exp_com_empty", exp_com.size(), 0);
    chk("exp_poll_empty", exp_poll.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
